// File: rtl/secded_pkg.sv
// Shared constants and types for the (13,8) extended-Hamming SECDED decoder.
package secded_pkg;

    localparam int unsigned CODE_W = 13;
    localparam int unsigned DATA_W = 8;

    localparam int unsigned IDX_P1 = 0;
    localparam int unsigned IDX_P2 = 1;
    localparam int unsigned IDX_D1 = 2;
    localparam int unsigned IDX_P4 = 3;
    localparam int unsigned IDX_D2 = 4;
    localparam int unsigned IDX_D3 = 5;
    localparam int unsigned IDX_D4 = 6;
    localparam int unsigned IDX_P8 = 7;
    localparam int unsigned IDX_D5 = 8;
    localparam int unsigned IDX_D6 = 9;
    localparam int unsigned IDX_D7 = 10;
    localparam int unsigned IDX_D8 = 11;
    localparam int unsigned IDX_WP = 12;

    localparam logic [CODE_W-1:0] MASK_S1 = 13'h0555;
    localparam logic [CODE_W-1:0] MASK_S2 = 13'h0666;
    localparam logic [CODE_W-1:0] MASK_S4 = 13'h0878;
    localparam logic [CODE_W-1:0] MASK_S8 = 13'h0F80;

    localparam logic [3:0] POS_WP = 4'd13;

    typedef enum logic [1:0] {OK, CORR, UNCORR} status_e;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        return {c[IDX_D8], c[IDX_D7], c[IDX_D6], c[IDX_D5],
                c[IDX_D4], c[IDX_D3], c[IDX_D2], c[IDX_D1]};
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity generator for one codeword.
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [3:0]        syndrome_o,
    output logic              parity_o
);

    always_comb begin
        syndrome_o = {^(code_i & MASK_S8), ^(code_i & MASK_S4),
                      ^(code_i & MASK_S2), ^(code_i & MASK_S1)};
        parity_o   = ^code_i;
    end

endmodule

// File: rtl/secded_decoder.sv
// Two-stage SECDED decoder with valid/ready handshakes and saturating error counters.
module secded_decoder
    import secded_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_single,
    output logic              err_double,
    output logic [3:0]        err_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q,  s1_code_d;
    logic [3:0]        s1_syn_q,   s1_syn_d;
    logic              s1_par_q,   s1_par_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              single_q,    single_d;
    logic              double_q,    double_d;
    logic [3:0]        pos_q,       pos_d;

    logic [CNT_W-1:0]  corr_cnt_q,   corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic              s2_load;
    logic              s1_adv;
    logic [3:0]        syn;
    logic              par;
    status_e           status;
    logic [CODE_W-1:0] fixed_code;
    logic [3:0]        fixed_pos;

    secded_syndrome u_syndrome (
        .code_i     (in_code),
        .syndrome_o (syn),
        .parity_o   (par)
    );

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_adv   = s2_load || !s1_valid_q;
    assign in_ready = s1_adv;

    // Classify the stage-1 codeword and apply the single-bit correction.
    always_comb begin
        status     = OK;
        fixed_code = s1_code_q;
        fixed_pos  = '0;
        if (s1_syn_q == 4'd0) begin
            if (s1_par_q) begin
                status    = CORR;
                fixed_pos = POS_WP;
            end
        end else if (s1_par_q && (s1_syn_q <= 4'd12)) begin
            status    = CORR;
            fixed_pos = s1_syn_q;
            for (int unsigned i = 0; i < 12; i++) begin
                if (s1_syn_q == 4'(i + 1)) begin
                    fixed_code[i] = ~s1_code_q[i];
                end
            end
        end else begin
            status = UNCORR;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        s1_par_d    = s1_par_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        single_d    = single_q;
        double_d    = double_q;
        pos_d       = pos_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code;
                s1_syn_d  = syn;
                s1_par_d  = par;
            end
        end

        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d   = extract_data(fixed_code);
                single_d = (status == CORR);
                double_d = (status == UNCORR);
                pos_d    = fixed_pos;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (single_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (double_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            single_q     <= 1'b0;
            double_q     <= 1'b0;
            pos_q        <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            out_valid_q  <= out_valid_d;
            data_q       <= data_d;
            single_q     <= single_d;
            double_q     <= double_d;
            pos_q        <= pos_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign data_out   = data_q;
    assign err_single = single_q;
    assign err_double = double_q;
    assign err_pos    = pos_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_secded_decoder.sv
// Randomised self-checking bench for secded_decoder against a position-XOR Hamming model.
module tb_secded_decoder;

    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [12:0]   in_code = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    data_out;
    logic          err_single;
    logic          err_double;
    logic [3:0]    err_pos;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    secded_decoder #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .err_single (err_single),
        .err_double (err_double),
        .err_pos    (err_pos),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       dd;
        logic [3:0] p;
    } res_t;

    res_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Hamming positions 1..12 map to bit index position-1; syndrome is XOR of set positions.
    function automatic res_t model(input logic [12:0] c);
        res_t       r;
        int         s;
        logic [12:0] w;
        int         dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        s = 0;
        for (int i = 0; i < 12; i++) if (c[i]) s = s ^ (i + 1);
        w    = c;
        r.s  = 1'b0;
        r.dd = 1'b0;
        r.p  = 4'd0;
        if (s == 0 && (^c) == 1'b1) begin
            r.s = 1'b1; r.p = 4'd13;
        end else if (s != 0 && (^c) == 1'b1 && s <= 12) begin
            r.s = 1'b1; r.p = 4'(s); w[s-1] = ~w[s-1];
        end else if (s != 0) begin
            r.dd = 1'b1;
        end
        for (int k = 0; k < 8; k++) r.d[k] = w[dpos[k]-1];
        return r;
    endfunction

    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] c;
        int          s;
        int          dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        c = '0;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            if (d[k]) begin
                c[dpos[k]-1] = 1'b1;
                s = s ^ dpos[k];
            end
        end
        c[0]  = s[0];
        c[1]  = s[1];
        c[3]  = s[2];
        c[7]  = s[3];
        c[12] = ^c[11:0];
        return c;
    endfunction

    function automatic logic [12:0] gen_code(input int kind);
        logic [12:0] c;
        int          a, b;
        c = encode(8'($urandom_range(0, 255)));
        a = $urandom_range(0, 12);
        b = (a + $urandom_range(1, 12)) % 13;
        case (kind)
            1:       c[a] = ~c[a];
            2:       begin c[a] = ~c[a]; c[b] = ~c[b]; end
            3:       c = 13'($urandom);
            default: ;
        endcase
        return c;
    endfunction

    // Scoreboard / monitor: sampled on the falling edge, mid-cycle.
    int          mc = 0;
    int          mu = 0;
    bit          seen_rst = 1'b0;
    bit          held_v = 1'b0;
    logic [14:0] held;
    res_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mc = 0; mu = 0;
            held_v = 1'b0;
            seen_rst = 1'b1;
        end else if (seen_rst) begin
            chk("corr_cnt", 32'(corr_cnt), 32'(mc));
            chk("uncorr_cnt", 32'(uncorr_cnt), 32'(mu));
            if (held_v)
                chk("stall_hold", 32'({out_valid, data_out, err_single, err_double, err_pos}), 32'(held));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result: got data %0h expected no result at %0t", data_out, $time);
                end else begin
                    e = q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e.d));
                    chk("err_single", 32'(err_single), 32'(e.s));
                    chk("err_double", 32'(err_double), 32'(e.dd));
                    chk("err_pos", 32'(err_pos), 32'(e.p));
                    if (!cnt_clr) begin
                        if (e.s && mc < MAXC) mc++;
                        if (e.dd && mu < MAXC) mu++;
                    end
                end
            end
            if (cnt_clr) begin mc = 0; mu = 0; end
            held_v = out_valid && !out_ready;
            held   = {out_valid, data_out, err_single, err_double, err_pos};
            if (in_valid && in_ready) q.push_back(model(in_code));
        end
    end

    task automatic directed(input logic [12:0] c, input logic [7:0] ed, input logic es,
                            input logic edd, input logic [3:0] ep, input int dc, input int du);
        logic [CW-1:0] c0, u0;
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_code = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("lat2_valid", 32'(out_valid), 32'd1);
        chk("lat2_data", 32'(data_out), 32'(ed));
        chk("lat2_single", 32'(err_single), 32'(es));
        chk("lat2_double", 32'(err_double), 32'(edd));
        chk("lat2_pos", 32'(err_pos), 32'(ep));
        c0 = corr_cnt; u0 = uncorr_cnt;
        @(posedge clk); #1;
        chk("corr_delta", 32'(corr_cnt), 32'(CW'(32'(c0) + dc)));
        chk("uncorr_delta", 32'(uncorr_cnt), 32'(CW'(32'(u0) + du)));
    endtask

    res_t r;
    bit   hs;
    int   tries;

    initial begin
        // Pin the model to hand-computed values.
        chk("enc_A5", 32'(encode(8'hA5)), 32'h0A27);
        r = model(13'h0A07);
        chk("model_d3", 32'({r.d, r.s, r.dd, r.p}), 32'({8'hA5, 1'b1, 1'b0, 4'd6}));
        r = model(13'h0A22);
        chk("model_dbl", 32'({r.d, r.s, r.dd, r.p}), 32'({8'hA4, 1'b0, 1'b1, 4'd0}));
        r = model(13'h1A27);
        chk("model_wp", 32'({r.d, r.s, r.dd, r.p}), 32'({8'hA5, 1'b1, 1'b0, 4'd13}));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_flags", 32'({err_single, err_double, err_pos}), 32'd0);
        chk("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        rst_n = 1'b1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        directed(13'h0A27, 8'hA5, 1'b0, 1'b0, 4'd0, 0, 0);
        directed(13'h0A07, 8'hA5, 1'b1, 1'b0, 4'd6, 1, 0);
        directed(13'h0A22, 8'hA4, 1'b0, 1'b1, 4'd0, 0, 1);
        directed(13'h1A27, 8'hA5, 1'b1, 1'b0, 4'd13, 1, 0);

        // Ten codewords held until accepted while out_ready toggles.
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_code  = gen_code(k % 4);
            tries    = 0;
            hs       = 1'b0;
            while (!hs && tries < 50) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                hs = in_ready;
                @(posedge clk); #1;
                tries++;
            end
            if (!hs) chk("burst_accept", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("burst_drained", 32'(q.size()), 32'd0);

        // Saturation then clear during a handshake.
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_code  = gen_code(1);
            if (model(in_code).p == 4'd0) in_code = 13'h0A07;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("corr_saturated", 32'(corr_cnt), 32'(MAXC));
        in_valid = 1'b1; in_code = 13'h0A07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tries = 0;
        while (!out_valid && tries < 10) begin @(posedge clk); #1; tries++; end
        chk("clr_wait", 32'(out_valid), 32'd1);
        chk("corr_before_clr", 32'(corr_cnt), 32'(MAXC));
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("corr_after_clr", 32'(corr_cnt), 32'd0);

        // Reset with codewords in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 13'h0A07;
        @(posedge clk); #1;
        in_code = 13'h0A22;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("no_stale", 32'(out_valid), 32'd0);
        end

        // Random traffic, stalls and occasional clears.
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            in_code   = gen_code($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
        tries = 0;
        while (q.size() != 0 && tries < 20) begin @(posedge clk); #1; tries++; end
        chk("final_drain", 32'(q.size()), 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/secded_decoder.md
SECDED_DECODER -- requirements
Module: secded_decoder

Interface
REQ-001 Parameter CNT_W, default 16: width of each saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  codeword on in_code is valid.
REQ-005 in_ready  output  1  decoder accepts in_code this cycle.
REQ-006 in_code  input  13  codeword: [0]P1 [1]P2 [2]D1 [3]P4 [4]D2 [5]D3 [6]D4 [7]P8 [8]D5 [9]D6 [10]D7 [11]D8 [12]WP.
REQ-007 out_valid  output  1  result fields are valid.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 data_out  output  8  corrected data, D8..D1 = [7:0].
REQ-010 err_single  output  1  single-bit error detected and corrected.
REQ-011 err_double  output  1  uncorrectable error detected.
REQ-012 err_pos  output  4  0 = none or uncorrectable; 1..12 = corrected codeword position (bit index + 1); 13 = WP bit.
REQ-013 cnt_clr  input  1  synchronous clear of both counters.
REQ-014 corr_cnt  output  CNT_W  saturating count of delivered err_single results.
REQ-015 uncorr_cnt  output  CNT_W  saturating count of delivered err_double results.

Function
REQ-016 Syndrome bits: s1 = XOR of code[0,2,4,6,8,10]; s2 = XOR of code[1,2,5,6,9,10]; s4 = XOR of code[3,4,5,6,11]; s8 = XOR of code[7,8,9,10,11]; S = {s8,s4,s2,s1}.
REQ-017 Overall parity check: P = XOR of code[12:0] (even parity expected).
REQ-018 S=0, P=0: no error; data passed through; flags 0; err_pos 0.
REQ-019 S=0, P=1: WP error; data unchanged; err_single=1; err_pos=13.
REQ-020 S in 1..12, P=1: invert code[S-1] before data extraction; err_single=1; err_pos=S.
REQ-021 S≠0, P=0, or S in 13..15 with P=1: err_double=1, err_single=0, err_pos=0, data_out = uncorrected data bits.
REQ-022 err_single and err_double are never both 1.
REQ-023 Two-stage pipeline: stage 1 registers S, P and raw code; stage 2 registers corrected data and status; latency 2 cycles from input handshake to out_valid with no stall.
REQ-024 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready; 1 result/cycle sustained when out_ready stays high.
REQ-025 Stage 2 loads when !out_valid | out_ready; stage 1 advances when stage 2 loads or stage 1 is empty; in_ready = !s1_valid | stage-2-load (combinational path from out_ready allowed).
REQ-026 While out_valid=1 and out_ready=0, all output fields hold stable; no codeword dropped or duplicated under any stall pattern.
REQ-027 Counters increment only on an output handshake carrying the matching flag; they saturate at 2^CNT_W-1 without wrapping.
REQ-028 cnt_clr=1 forces both counters to 0 next cycle, overriding a simultaneous increment; it does not affect the pipeline.

Reset
REQ-029 rst_n=0 at a clock edge clears s1_valid, out_valid, data_out, err_single, err_double, err_pos, corr_cnt and uncorr_cnt to 0.
REQ-030 in_ready is 1 in the first cycle after reset release.
REQ-031 Reset mid-operation discards all in-flight codewords; no result for them is ever presented.

Structure
REQ-032 Package secded_pkg holds codeword bit-index constants, the four syndrome coverage masks, the WP position code (13) and the status enum {OK, CORR, UNCORR}.
REQ-033 Sub-module secded_syndrome is purely combinational: in_code in, S and P out; it is instantiated once in stage 1.

Verification
REQ-034 in_code=0x0A27, out_ready=1 -> two cycles later data_out=0xA5, err_single=0, err_double=0, err_pos=0.
REQ-035 in_code=0x0A07 (D3 flipped) -> data_out=0xA5, err_single=1, err_pos=6, corr_cnt increments by 1.
REQ-036 in_code=0x0A22 (P1 and D1 flipped) -> err_double=1, err_pos=0, uncorr_cnt increments; in_code=0x1A27 -> data_out=0xA5, err_pos=13.
REQ-037 Send 10 back-to-back codewords while out_ready toggles pseudo-randomly -> all 10 results delivered in order, fields stable during stalls.
REQ-038 CNT_W=4, 20 single-error codewords, then cnt_clr asserted during a handshake -> corr_cnt holds at 15, then reads 0.
REQ-039 Assert rst_n=0 with 2 codewords in flight -> out_valid=0 and counters 0 after the edge; no stale result after release.
